pump_valve_sequencer: RTL and testbench
=======================================

Name: pump_valve_sequencer

Overview:
- Parametrised control-layer sequencer for microfluidic assays.
- Accepts one step command at a time over a valid/ready handshake and drives the pad-level control signals:
  - valve pressure lines (ctrl),
  - 3-valve peristaltic pump lines (pump),
  - matching flush lines (flush).
- Generalises fixed-width ctrl/pump/flush pad groups to N_VALVE valves and N_PUMP pumps.
- Adds timed settle, stroke-counted pumping, optional flush and abort.

Parameters:
N_VALVE, 13, number of independent control valves
N_PUMP, 2, number of peristaltic pumps (3 valve lines each)
CNT_W, 8, width of stroke count
TICK_W, 16, width of internal timer
SETTLE_TICKS, 4, cycles to hold valve mask before pumping (>=1)
PHASE_TICKS, 8, cycles each pump phase is held (>=1)
FLUSH_TICKS, 16, cycles flush lines are asserted (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  block can accept command
cmd_valve  in  N_VALVE  valve mask, 1 = pressurised/closed
cmd_pump_en  in  N_PUMP  pumps to run
cmd_strokes  in  CNT_W  full pump strokes to run
cmd_flush  in  1  run flush phase after pumping
abort  in  1  terminate current command
ctrl_valve  out  N_VALVE  valve control lines
ctrl_pump  out  3*N_PUMP  pump lines; pump i uses bits [3i+2:3i], bit 3i = inlet
flush_valve  out  N_VALVE  valve flush lines
flush_pump  out  3*N_PUMP  pump flush lines
busy  out  1  command in progress
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
stroke_count  out  CNT_W  strokes completed in current/last command

Behaviour:
- Reset values:
  - ctrl_valve = 0, ctrl_pump = all 1s (all pump valves closed).
  - flush_valve = 0, flush_pump = 0.
  - busy = 0, done = 0, aborted = 0, stroke_count = 0.
  - State = IDLE.
- cmd_ready = (state == IDLE) && !abort. It is combinational and therefore 1 out of reset.
- IDLE:
  - On cmd_valid && cmd_ready at edge k, latch all cmd_* fields, clear stroke_count and enter SETTLE.
  - ctrl_valve = latched cmd_valve from cycle k+1.
  - busy = 1 from k+1.
- SETTLE:
  - Hold for exactly SETTLE_TICKS cycles with pumps at 111.
  - On exit:
    - If cmd_strokes == 0 or cmd_pump_en == 0, go to FLUSH if cmd_flush, else finish.
    - Otherwise go to PUMP, phase 0.
- PUMP:
  - Phase p = 0..5, each held PHASE_TICKS cycles.
  - Enabled pumps drive the pattern for phase p: 110, 100, 101, 001, 011, 010. Disabled pumps drive 111.
  - After phase 5 completes, stroke_count increments.
    - If the new count == cmd_strokes, exit; otherwise return to phase 0.
  - Exit goes to FLUSH if cmd_flush, else finish.
  - Pump duration = 6*PHASE_TICKS*cmd_strokes cycles.
- FLUSH:
  - FLUSH_TICKS cycles with ctrl_valve = 0 and ctrl_pump = 111.
  - flush_valve = latched valve mask.
  - flush_pump = 111 for each enabled pump, 000 otherwise.
  - On exit, flush outputs return to 0 and ctrl_valve stays 0.
- Finish:
  - Return to IDLE with done = 1 for one cycle and busy = 0 in that same cycle.
  - Without flush, ctrl_valve keeps the latched mask in IDLE; ctrl_pump = 111.
  - stroke_count holds until the next accept.
- A new command can be accepted in the cycle done is high.
- abort while busy:
  - At the next edge, go to IDLE.
  - ctrl_valve = 0, ctrl_pump = 111, flush outputs = 0.
  - aborted pulses for one cycle; done does not pulse.
  - stroke_count keeps its partial value.
- abort in IDLE has no effect other than deasserting cmd_ready.
- Timer and stroke counter saturate at no point. Parameter legality: each *_TICKS < 2^TICK_W.
- rst_n asserted mid-command returns all outputs to reset values immediately. No done or aborted pulse is generated.

Test Plan (bench overrides SETTLE_TICKS=2, PHASE_TICKS=1, FLUSH_TICKS=3, N_VALVE=4, N_PUMP=2):
1. Accept valve=1010, pump_en=01, strokes=2, flush=0 at edge k:
   - ctrl_valve = 1010 from k+1.
   - Pump0 sequence 110, 100, 101, 001, 011, 010 twice starting at k+3; pump1 = 111 throughout.
   - stroke_count reaches 2; done at k+15; ctrl_valve still 1010 afterwards.
2. Same command with flush=1:
   - After pumping, 3 cycles of flush_valve = 1010, flush_pump = 000111, ctrl_valve = 0.
   - Then done.
3. strokes=0, flush=0:
   - SETTLE for 2 cycles, then done, with no pump activity and stroke_count = 0.
4. abort asserted during PUMP phase 3 of stroke 1:
   - Next cycle ctrl_valve = 0, ctrl_pump = 111111, aborted = 1, done = 0, stroke_count = 0.
   - cmd_ready is low while abort is held.
5. cmd_valid held high across two commands:
   - Second command is accepted in the done cycle; cmd_ready is low for the whole first command.
6. rst_n pulsed low mid-FLUSH:
   - All outputs return to reset values asynchronously; after release, cmd_ready = 1 and no done pulse occurs.

Source files
------------

// File: rtl/pump_valve_sequencer.sv
// Pump/valve step sequencer for microfluidic assays.
// Accepts one step command at a time, holds the valve mask through a settle
// window, runs stroke-counted peristaltic pumping, optionally flushes, and
// reports completion or abort with single-cycle pulses.
module pump_valve_sequencer #(
  parameter int N_VALVE      = 13,
  parameter int N_PUMP       = 2,
  parameter int CNT_W        = 8,
  parameter int TICK_W       = 16,
  parameter int SETTLE_TICKS = 4,
  parameter int PHASE_TICKS  = 8,
  parameter int FLUSH_TICKS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [N_VALVE-1:0]    cmd_valve,
  input  logic [N_PUMP-1:0]     cmd_pump_en,
  input  logic [CNT_W-1:0]      cmd_strokes,
  input  logic                  cmd_flush,
  input  logic                  abort,
  output logic [N_VALVE-1:0]    ctrl_valve,
  output logic [3*N_PUMP-1:0]   ctrl_pump,
  output logic [N_VALVE-1:0]    flush_valve,
  output logic [3*N_PUMP-1:0]   flush_pump,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      stroke_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, PUMP, FLUSH} state_t;

  // Last timer value of each timed window (timer counts 0 .. TICKS-1).
  localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE_TICKS - 1);
  localparam logic [TICK_W-1:0] PHASE_LAST  = TICK_W'(PHASE_TICKS - 1);
  localparam logic [TICK_W-1:0] FLUSH_LAST  = TICK_W'(FLUSH_TICKS - 1);

  state_t              state, state_next;
  logic [TICK_W-1:0]   timer, timer_next;
  logic [2:0]          phase, phase_next;
  logic [CNT_W-1:0]    strokes_next, stroke_inc;
  logic                done_next, aborted_next;
  logic                hold, hold_next;   // ctrl_valve shows the latched mask
  logic                load, work_done;

  // Latched command fields.
  logic [N_VALVE-1:0]  valve_q;
  logic [N_PUMP-1:0]   pump_en_q;
  logic [CNT_W-1:0]    strokes_q;
  logic                flush_q;

  // Peristaltic pattern for one phase; bit 0 is the inlet, 1 = closed.
  function automatic logic [2:0] phase_pattern(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b110;
      3'd1:    return 3'b100;
      3'd2:    return 3'b101;
      3'd3:    return 3'b001;
      3'd4:    return 3'b011;
      3'd5:    return 3'b010;
      default: return 3'b111;
    endcase
  endfunction

  assign cmd_ready  = (state == IDLE) && !abort;
  assign busy       = (state != IDLE);
  assign stroke_inc = stroke_count + CNT_W'(1);

  // Next-state, timer, phase and stroke bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next   = state;
    timer_next   = timer + TICK_W'(1);
    phase_next   = phase;
    strokes_next = stroke_count;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    hold_next    = hold;
    load         = 1'b0;
    work_done    = 1'b0;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (cmd_valid && cmd_ready) begin
          load         = 1'b1;
          strokes_next = '0;
          hold_next    = 1'b1;
          state_next   = SETTLE;
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          timer_next = '0;
          if (strokes_q == '0 || pump_en_q == '0) begin
            work_done = 1'b1;
          end else begin
            state_next = PUMP;
            phase_next = '0;
          end
        end
      end
      PUMP: begin
        if (timer == PHASE_LAST) begin
          timer_next = '0;
          if (phase == 3'd5) begin
            phase_next   = '0;
            strokes_next = stroke_inc;
            if (stroke_inc == strokes_q) work_done = 1'b1;
          end else begin
            phase_next = phase + 3'd1;
          end
        end
      end
      FLUSH: begin
        if (timer == FLUSH_LAST) begin
          timer_next = '0;
          hold_next  = 1'b0;
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Pumping (or settle with nothing to pump) finished: flush or complete.
    if (work_done) begin
      if (flush_q) begin
        state_next = FLUSH;
        timer_next = '0;
      end else begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end

    // Abort overrides everything while a command is in flight; the partial
    // stroke count is kept.
    if (state != IDLE && abort) begin
      state_next   = IDLE;
      timer_next   = '0;
      phase_next   = '0;
      strokes_next = stroke_count;
      done_next    = 1'b0;
      aborted_next = 1'b1;
      hold_next    = 1'b0;
    end
  end

  // State, counters, status pulses and latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      phase        <= '0;
      stroke_count <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      hold         <= 1'b0;
      valve_q      <= '0;
      pump_en_q    <= '0;
      strokes_q    <= '0;
      flush_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state        <= state_next;
      timer        <= timer_next;
      phase        <= phase_next;
      stroke_count <= strokes_next;
      done         <= done_next;
      aborted      <= aborted_next;
      hold         <= hold_next;
      if (load) begin
        valve_q   <= cmd_valve;
        pump_en_q <= cmd_pump_en;
        strokes_q <= cmd_strokes;
        flush_q   <= cmd_flush;
      end
    end
  end

  // Pad-level control and flush lines decoded from the current state.
  always_comb begin
    ctrl_valve  = (hold && state != FLUSH) ? valve_q : '0;
    ctrl_pump   = '1;
    flush_valve = '0;
    flush_pump  = '0;
    if (state == PUMP) begin
      for (int i = 0; i < N_PUMP; i++) begin
        if (pump_en_q[i]) ctrl_pump[3*i +: 3] = phase_pattern(phase);
      end
    end
    if (state == FLUSH) begin
      flush_valve = valve_q;
      for (int i = 0; i < N_PUMP; i++) begin
        flush_pump[3*i +: 3] = {3{pump_en_q[i]}};
      end
    end
  end

endmodule

// File: tb/tb_pump_valve_sequencer.sv
// Self-checking bench for pump_valve_sequencer: directed scenarios plus
// randomized commands, all compared cycle by cycle against a timeline model.
module tb_pump_valve_sequencer;

  localparam int NV  = 4;
  localparam int NP  = 2;
  localparam int CW  = 8;
  localparam int SET = 2;
  localparam int PH  = 1;
  localparam int FL  = 3;

  localparam logic [2:0] PAT [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_flush = 1'b0;
  logic            abort = 1'b0;
  logic [NV-1:0]   cmd_valve = '0;
  logic [NP-1:0]   cmd_pump_en = '0;
  logic [CW-1:0]   cmd_strokes = '0;
  logic            cmd_ready, busy, done, aborted;
  logic [NV-1:0]   ctrl_valve, flush_valve;
  logic [3*NP-1:0] ctrl_pump, flush_pump;
  logic [CW-1:0]   stroke_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] strokes;
    logic [NV-1:0] cv;
    logic [3*NP-1:0] cp;
    logic [NV-1:0] fv;
    logic [3*NP-1:0] fp;
  } snap_t;

  typedef struct packed {
    logic [NV-1:0] valve;
    logic [NP-1:0] en;
    logic [CW-1:0] strokes;
    logic          flush;
  } cmd_t;

  pump_valve_sequencer #(
    .N_VALVE(NV), .N_PUMP(NP), .CNT_W(CW), .TICK_W(16),
    .SETTLE_TICKS(SET), .PHASE_TICKS(PH), .FLUSH_TICKS(FL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_valve(cmd_valve), .cmd_pump_en(cmd_pump_en),
    .cmd_strokes(cmd_strokes), .cmd_flush(cmd_flush),
    .abort(abort),
    .ctrl_valve(ctrl_valve), .ctrl_pump(ctrl_pump),
    .flush_valve(flush_valve), .flush_pump(flush_pump),
    .busy(busy), .done(done), .aborted(aborted),
    .stroke_count(stroke_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic snap_t observe();
    snap_t s;
    s.ready = cmd_ready;  s.busy = busy;  s.done = done;  s.aborted = aborted;
    s.strokes = stroke_count;
    s.cv = ctrl_valve;  s.cp = ctrl_pump;  s.fv = flush_valve;  s.fp = flush_pump;
    return s;
  endfunction

  function automatic snap_t reset_snap();
    snap_t s;
    s = '0;
    s.ready = 1'b1;
    s.cp = '1;
    return s;
  endfunction

  function automatic int pump_cycles(input cmd_t c);
    return (c.strokes != 0 && c.en != 0) ? 6 * PH * int'(c.strokes) : 0;
  endfunction

  // Cycles from accept to the done cycle inclusive.
  function automatic int cmd_len(input cmd_t c);
    return SET + pump_cycles(c) + (c.flush ? FL : 0) + 1;
  endfunction

  // Expected outputs in cycle t after the accepting edge (t = 1 is the first
  // cycle of the command), assuming abort stays low. Built from the phase
  // timeline: settle window, pump window, flush window, done, idle.
  function automatic snap_t model_snap(input cmd_t c, input int t);
    snap_t s;
    int p, f, u;
    p = pump_cycles(c);
    f = c.flush ? FL : 0;
    s = reset_snap();
    s.strokes = (p != 0) ? c.strokes : '0;
    s.cv = c.flush ? '0 : c.valve;
    if (t <= SET) begin
      s.ready = 1'b0;  s.busy = 1'b1;  s.strokes = '0;  s.cv = c.valve;
    end else if (t <= SET + p) begin
      u = t - SET - 1;
      s.ready = 1'b0;  s.busy = 1'b1;  s.cv = c.valve;
      s.strokes = CW'(u / (6 * PH));
      for (int i = 0; i < NP; i++)
        if (c.en[i]) s.cp[3*i +: 3] = PAT[(u / PH) % 6];
    end else if (t <= SET + p + f) begin
      s.ready = 1'b0;  s.busy = 1'b1;  s.cv = '0;  s.fv = c.valve;
      for (int i = 0; i < NP; i++) s.fp[3*i +: 3] = {3{c.en[i]}};
    end else if (t == SET + p + f + 1) begin
      s.done = 1'b1;
    end
    return s;
  endfunction

  task automatic issue(input cmd_t c);
    @(posedge clk); #1;
    cmd_valve = c.valve;  cmd_pump_en = c.en;  cmd_strokes = c.strokes;  cmd_flush = c.flush;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    snap_t got;
    repeat (2) @(negedge clk);
    got = observe();  vectors++;
    if (got !== reset_snap()) begin
      miscompares++;  $display("FAIL reset_held got=%h exp=%h", got, reset_snap());
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = observe();  vectors++;
    if (got !== reset_snap()) begin
      miscompares++;  $display("FAIL reset_release got=%h exp=%h", got, reset_snap());
    end
  endtask

  task automatic test_pump(input string name, input cmd_t c);
    snap_t got, exp;
    issue(c);
    for (int t = 1; t <= cmd_len(c) + 2; t++) begin
      @(negedge clk);
      got = observe();  exp = model_snap(c, t);  vectors++;
      if (got !== exp) begin
        miscompares++;  $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
      end
    end
  endtask

  task automatic test_abort();
    snap_t got, exp;
    cmd_t c;
    int ta;
    c = '{valve: 4'b1100, en: 2'b11, strokes: 8'd3, flush: 1'b1};
    ta = SET + 1 + 3 * PH;   // PUMP phase 3 of the first stroke
    issue(c);
    for (int t = 1; t <= ta; t++) begin
      @(negedge clk);
      got = observe();  exp = model_snap(c, t);  vectors++;
      if (got !== exp) begin
        miscompares++;  $display("FAIL abort_pre t=%0d got=%h exp=%h", t, got, exp);
      end
    end
    abort = 1'b1;
    @(negedge clk);
    exp = reset_snap();  exp.ready = 1'b0;  exp.aborted = 1'b1;
    got = observe();  vectors++;
    if (got !== exp) begin
      miscompares++;  $display("FAIL abort_pulse got=%h exp=%h", got, exp);
    end
    @(negedge clk);
    exp.aborted = 1'b0;
    got = observe();  vectors++;
    if (got !== exp) begin
      miscompares++;  $display("FAIL abort_held_idle got=%h exp=%h", got, exp);
    end
    abort = 1'b0;
    @(negedge clk);
    exp.ready = 1'b1;
    got = observe();  vectors++;
    if (got !== exp) begin
      miscompares++;  $display("FAIL abort_release got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    snap_t got, exp;
    cmd_t c1, c2;
    c1 = '{valve: 4'b0101, en: 2'b10, strokes: 8'd1, flush: 1'b0};
    c2 = '{valve: 4'b0011, en: 2'b11, strokes: 8'd1, flush: 1'b1};
    @(posedge clk); #1;
    cmd_valve = c1.valve;  cmd_pump_en = c1.en;  cmd_strokes = c1.strokes;  cmd_flush = c1.flush;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= cmd_len(c1); t++) begin
      @(negedge clk);
      got = observe();  exp = model_snap(c1, t);  vectors++;
      if (got !== exp) begin
        miscompares++;  $display("FAIL b2b_first t=%0d got=%h exp=%h", t, got, exp);
      end
    end
    cmd_valve = c2.valve;  cmd_pump_en = c2.en;  cmd_strokes = c2.strokes;  cmd_flush = c2.flush;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int t = 1; t <= cmd_len(c2) + 1; t++) begin
      @(negedge clk);
      got = observe();  exp = model_snap(c2, t);  vectors++;
      if (got !== exp) begin
        miscompares++;  $display("FAIL b2b_second t=%0d got=%h exp=%h", t, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    snap_t got, exp;
    cmd_t c;
    int tf;
    c = '{valve: 4'b1010, en: 2'b01, strokes: 8'd1, flush: 1'b1};
    tf = SET + pump_cycles(c) + 1;   // first flush cycle
    issue(c);
    for (int t = 1; t <= tf; t++) begin
      @(negedge clk);
      got = observe();  exp = model_snap(c, t);  vectors++;
      if (got !== exp) begin
        miscompares++;  $display("FAIL rstflush_pre t=%0d got=%h exp=%h", t, got, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got = observe();  vectors++;
    if (got !== reset_snap()) begin
      miscompares++;  $display("FAIL rstflush_async got=%h exp=%h", got, reset_snap());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      got = observe();  vectors++;
      if (got !== reset_snap()) begin
        miscompares++;  $display("FAIL rstflush_after t=%0d got=%h exp=%h", t, got, reset_snap());
      end
    end
  endtask

  task automatic test_random(input int n);
    snap_t got, exp;
    cmd_t c;
    int ta;
    for (int k = 0; k < n; k++) begin
      c.valve   = NV'($urandom);
      c.en      = NP'($urandom_range(0, 3));
      c.strokes = CW'($urandom_range(0, 3));
      c.flush   = 1'($urandom_range(0, 1));
      ta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cmd_len(c) - 1) : 0;
      issue(c);
      for (int t = 1; t <= ((ta != 0) ? ta : cmd_len(c) + 1); t++) begin
        @(negedge clk);
        got = observe();  exp = model_snap(c, t);  vectors++;
        if (got !== exp) begin
          miscompares++;  $display("FAIL random k=%0d t=%0d got=%h exp=%h", k, t, got, exp);
        end
      end
      if (ta != 0) begin
        exp = reset_snap();
        exp.ready = 1'b0;  exp.aborted = 1'b1;
        exp.strokes = model_snap(c, ta).strokes;
        abort = 1'b1;
        @(negedge clk);
        got = observe();  vectors++;
        if (got !== exp) begin
          miscompares++;  $display("FAIL random_abort k=%0d ta=%0d got=%h exp=%h", k, ta, got, exp);
        end
        abort = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pump("basic",       '{valve: 4'b1010, en: 2'b01, strokes: 8'd2, flush: 1'b0});
    test_pump("with_flush",  '{valve: 4'b1010, en: 2'b01, strokes: 8'd2, flush: 1'b1});
    test_pump("zero_stroke", '{valve: 4'b0110, en: 2'b11, strokes: 8'd0, flush: 1'b0});
    test_abort();
    test_back_to_back();
    test_reset_mid_flush();
    test_random(24);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
